// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencing with a mem_ready wait-state handshake.
// Optional performance counters (cycle_cnt, instr_cnt) are enabled by defining MIPS_PERF_CNT_EN.
module multi_cycle_mips #(
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        IR_addr,
  input  logic [31:0]        IR,
  input  logic [31:0]        ReadDataMem,
  input  logic               mem_ready,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        Data2Mem
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
  logic [31:0] gpr [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext;
  logic        is_rtype_alu, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_valid;
  logic        branch_taken;
  logic [31:0] add_a, add_b, add_sum, alu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign shamt    = ir_reg[10:6];
  assign funct    = ir_reg[5:0];
  assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

  always_comb begin
    is_rtype_alu = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02: is_rtype_alu = 1'b1;
        default:                                          is_rtype_alu = 1'b0;
      endcase
    end
  end

  assign is_jr    = (opcode == 6'h00) && (funct == 6'h08);
  assign is_j     = (opcode == 6'h02);
  assign is_jal   = (opcode == 6'h03);
  assign is_beq   = (opcode == 6'h04);
  assign is_bne   = (opcode == 6'h05);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2b);
  assign is_valid = is_rtype_alu | is_jr | is_j | is_jal | is_beq | is_bne | is_lw | is_sw;
  assign branch_taken = (is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg));

  // One adder serves PC+4, the branch target and the effective address.
  always_comb begin
    add_a = pc_reg;
    add_b = 32'd4;
    case (state_reg)
      S_DECODE: add_b = {imm_sext[29:0], 2'b00};
      S_EXEC: begin
        add_a = a_reg;
        add_b = (is_lw || is_sw) ? imm_sext : b_reg;
      end
      default: ;
    endcase
  end
  assign add_sum = add_a + add_b;

  always_comb begin
    alu_result = '0;
    case (funct)
      6'h20:   alu_result = add_sum;
      6'h22:   alu_result = a_reg - b_reg;
      6'h24:   alu_result = a_reg & b_reg;
      6'h25:   alu_result = a_reg | b_reg;
      6'h2a:   alu_result = {31'b0, $signed(a_reg) < $signed(b_reg)};
      6'h00:   alu_result = b_reg << shamt;
      6'h02:   alu_result = b_reg >> shamt;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = (is_j || is_jal || !is_valid) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (is_rtype_alu)       state_next = S_WB;
        else if (is_lw || is_sw) state_next = S_MEM;
        else                     state_next = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
      end
      S_WB:     state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          ir_reg <= IR;
          pc_reg <= add_sum;
        end
        S_DECODE: begin
          a_reg       <= gpr[rs];
          b_reg       <= gpr[rt];
          alu_out_reg <= add_sum;
          if (is_j || is_jal) pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
        end
        S_EXEC: begin
          if (is_rtype_alu)        alu_out_reg <= alu_result;
          if (is_lw || is_sw)      alu_out_reg <= add_sum;
          if (is_jr)               pc_reg      <= a_reg;
          else if (branch_taken)   pc_reg      <= alu_out_reg;
        end
        S_MEM: begin
          if (mem_ready && is_lw) mdr_reg <= ReadDataMem;
        end
        default: ;
      endcase
    end
  end

  // jal links in DECODE; WB covers both R-type and lw results.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state_reg == S_DECODE && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc_reg;
    end else if (state_reg == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = is_lw ? rt : rd;
      rf_wdata = is_lw ? mdr_reg : alu_out_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      gpr[rf_waddr] <= rf_wdata;
    end
  end

  assign IR_addr  = pc_reg;
  assign CEN      = !(state_reg == S_MEM);
  assign OEN      = !(state_reg == S_MEM && is_lw);
  assign WEN      = !(state_reg == S_MEM && is_sw);
  assign A        = alu_out_reg[DMEM_AW+1:2];
  assign Data2Mem = b_reg;

`ifdef MIPS_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state_next == S_FETCH) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed bench for multi_cycle_mips: instruction table with cycle counts, PC and store checks,
// plus hand sequences for reset, store strobes with wait states and reset during an access.
module tb_multi_cycle_mips;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_addr, IR, ReadDataMem, Data2Mem;
  logic        mem_ready, CEN, WEN, OEN;
  logic [6:0]  A;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multi_cycle_mips #(.DMEM_AW(7), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IR_addr     (IR_addr),
    .IR          (IR),
    .ReadDataMem (ReadDataMem),
    .mem_ready   (mem_ready),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem)
`ifdef MIPS_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  // Instruction supply ignores the address: the bench presents one word per transaction.
  logic [31:0] ir_word;
  assign IR = ir_word;

  // Data memory with a programmable number of wait cycles per access.
  logic [31:0] dmem [128];
  int          wait_cycles;
  int          wait_cnt = 0;
  int          wr_cnt   = 0;
  logic [6:0]  wr_addr_log;
  logic [31:0] wr_data_log;

  assign mem_ready   = !CEN && (wait_cnt >= wait_cycles);
  assign ReadDataMem = dmem[A];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) dmem[i] <= '0;
      dmem[0] <= 32'd5;
      dmem[1] <= 32'hFFFF_FFFE;
    end else if (!CEN && !WEN && mem_ready) begin
      dmem[A]     <= Data2Mem;
      wr_cnt      <= wr_cnt + 1;
      wr_addr_log <= A;
      wr_data_log <= Data2Mem;
    end
    if (CEN || mem_ready) wait_cnt <= 0;
    else                  wait_cnt <= wait_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          waits;
    int          cycles;
    logic [31:0] pc_after;
    bit          wr;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string n, input logic [31:0] ins, input int w, input int c,
                         input logic [31:0] pc, input bit wr, input logic [6:0] wa,
                         input logic [31:0] wd);
    vec_t t;
    t.name = n; t.instr = ins; t.waits = w; t.cycles = c;
    t.pc_after = pc; t.wr = wr; t.wr_addr = wa; t.wr_data = wd;
    vq.push_back(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t v;
  int   wr_before;
  int   wen_low;
  int   oen_low;
  logic [6:0] a_at_mem;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // name, instr, waits, cycles, pc_after, store?, store addr, store data
    add_vec("lw $1,0",       32'h8C010000, 0, 5, 32'h04, 0, 7'd0,  32'h0);
    add_vec("lw $2,4",       32'h8C020004, 0, 5, 32'h08, 0, 7'd0,  32'h0);
    add_vec("add $3",        32'h00221820, 0, 4, 32'h0C, 0, 7'd0,  32'h0);
    add_vec("slt $4",        32'h0041202A, 0, 4, 32'h10, 0, 7'd0,  32'h0);
    add_vec("sub $6",        32'h00413022, 0, 4, 32'h14, 0, 7'd0,  32'h0);
    add_vec("and $7",        32'h00223824, 0, 4, 32'h18, 0, 7'd0,  32'h0);
    add_vec("or $8",         32'h00224025, 0, 4, 32'h1C, 0, 7'd0,  32'h0);
    add_vec("sll $9",        32'h00014900, 0, 4, 32'h20, 0, 7'd0,  32'h0);
    add_vec("srl $10",       32'h00025702, 0, 4, 32'h24, 0, 7'd0,  32'h0);
    add_vec("sw $3 wait2",   32'hAC030008, 2, 6, 32'h28, 1, 7'd2,  32'd3);
    add_vec("lw $5 wait2",   32'h8C050008, 2, 7, 32'h2C, 0, 7'd0,  32'h0);
    add_vec("sw $5",         32'hAC05000C, 0, 4, 32'h30, 1, 7'd3,  32'd3);
    add_vec("sw $4",         32'hAC040010, 0, 4, 32'h34, 1, 7'd4,  32'd1);
    add_vec("sw $6",         32'hAC060014, 0, 4, 32'h38, 1, 7'd5,  32'hFFFF_FFF9);
    add_vec("sw $7",         32'hAC070018, 0, 4, 32'h3C, 1, 7'd6,  32'd4);
    add_vec("sw $8",         32'hAC08001C, 0, 4, 32'h40, 1, 7'd7,  32'hFFFF_FFFF);
    add_vec("sw $9",         32'hAC090020, 0, 4, 32'h44, 1, 7'd8,  32'h50);
    add_vec("sw $10",        32'hAC0A0024, 0, 4, 32'h48, 1, 7'd9,  32'hF);
    add_vec("add $0",        32'h00210020, 0, 4, 32'h4C, 0, 7'd0,  32'h0);
    add_vec("sw $0",         32'hAC000028, 0, 4, 32'h50, 1, 7'd10, 32'h0);
    add_vec("sw addr wrap",  32'hAC010204, 0, 4, 32'h54, 1, 7'd1,  32'd5);
    add_vec("nop opcode",    32'hFC000000, 0, 2, 32'h58, 0, 7'd0,  32'h0);
    add_vec("nop funct",     32'h00221821, 0, 2, 32'h5C, 0, 7'd0,  32'h0);
    add_vec("beq taken -1",  32'h1000FFFF, 0, 3, 32'h5C, 0, 7'd0,  32'h0);
    add_vec("bne not taken", 32'h14000005, 0, 3, 32'h60, 0, 7'd0,  32'h0);
    add_vec("bne taken +3",  32'h14220003, 0, 3, 32'h70, 0, 7'd0,  32'h0);
    add_vec("beq not taken", 32'h10220003, 0, 3, 32'h74, 0, 7'd0,  32'h0);
    add_vec("jal 0x40",      32'h0C000010, 0, 2, 32'h40, 0, 7'd0,  32'h0);
    add_vec("jr $31",        32'h03E00008, 0, 3, 32'h78, 0, 7'd0,  32'h0);
    add_vec("sw $31",        32'hAC1F002C, 0, 4, 32'h7C, 1, 7'd11, 32'h78);
    add_vec("j 0x100",       32'h08000040, 0, 2, 32'h100, 0, 7'd0, 32'h0);

    // Reset state, then the first FETCH.
    ir_word = 32'hFC000000;
    wait_cycles = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset IR_addr", IR_addr, 32'h0);
    check32("reset CEN", 32'(CEN), 32'd1);
    check32("reset WEN", 32'(WEN), 32'd1);
    check32("reset OEN", 32'(OEN), 32'd1);
    check32("reset A", 32'(A), 32'h0);
    check32("reset Data2Mem", Data2Mem, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check32("first fetch IR_addr", IR_addr, 32'h4);
    check32("first fetch CEN", 32'(CEN), 32'd1);
    rst_n = 1'b0;
    #1;
    check32("async reset IR_addr", IR_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Program table: each entry runs for exactly its expected cycle count.
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      ir_word = v.instr;
      wait_cycles = v.waits;
      wr_before = wr_cnt;
      repeat (v.cycles) @(posedge clk);
      #1;
      check32({v.name, " pc"}, IR_addr, v.pc_after);
      check32({v.name, " writes"}, 32'(wr_cnt - wr_before), v.wr ? 32'd1 : 32'd0);
      if (v.wr) begin
        check32({v.name, " wr addr"}, 32'(wr_addr_log), 32'(v.wr_addr));
        check32({v.name, " wr data"}, wr_data_log, v.wr_data);
      end
      $display("vec %0d %s: pc=0x%08h writes=%0d", i, v.name, IR_addr, wr_cnt - wr_before);
    end

    // Store strobes across two wait states: WEN low for the whole three-cycle MEM.
    ir_word = 32'hAC030008;
    wait_cycles = 2;
    wr_before = wr_cnt;
    wen_low = 0;
    oen_low = 0;
    a_at_mem = '0;
    for (int c = 0; c < 6; c++) begin
      if (!WEN) begin
        wen_low++;
        a_at_mem = A;
      end
      if (!OEN) oen_low++;
      @(posedge clk); #1;
    end
    check32("sw strobe WEN cycles", 32'(wen_low), 32'd3);
    check32("sw strobe A", 32'(a_at_mem), 32'd2);
    check32("sw strobe OEN cycles", 32'(oen_low), 32'd0);
    check32("sw strobe pc", IR_addr, 32'h104);
    check32("sw strobe write data", wr_data_log, 32'd3);
    $display("seq sw strobes: wen_low=%0d A=%0d pc=0x%08h", wen_low, a_at_mem, IR_addr);

    // Reset while a store waits in MEM: strobes drop at once and no write lands.
    ir_word = 32'hAC01003C;
    wait_cycles = 100;
    wr_before = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    check32("mid MEM WEN", 32'(WEN), 32'd0);
    check32("mid MEM A", 32'(A), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    check32("abort WEN", 32'(WEN), 32'd1);
    check32("abort CEN", 32'(CEN), 32'd1);
    check32("abort IR_addr", IR_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check32("abort no write", 32'(wr_cnt - wr_before), 32'd0);
    rst_n = 1'b1;
    ir_word = 32'hFC000000;
    @(posedge clk); #1;
    check32("restart IR_addr", IR_addr, 32'h4);
    $display("seq reset mid MEM: writes=%0d pc=0x%08h", wr_cnt - wr_before, IR_addr);

`ifdef MIPS_PERF_CNT_EN
    do_reset();
    ir_word = 32'h00221820;
    repeat (16) @(posedge clk);
    #1;
    check32("perf instr_cnt", instr_cnt, 32'd4);
    check32("perf cycle_cnt", cycle_cnt, 32'd16);
    $display("seq perf: instr_cnt=%0d cycle_cnt=%0d", instr_cnt, cycle_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
